// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg: FSM state encoding and register map for the PWM capture block.
package pwm_capture_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEASURE   = 2'd2,
    DONE      = 2'd3
  } state_e;
  localparam logic [1:0] ADDR_PERIOD  = 2'd0;
  localparam logic [1:0] ADDR_HIGH    = 2'd1;
  localparam logic [1:0] ADDR_NCAP    = 2'd2;
  localparam logic [1:0] ADDR_TIMEOUT = 2'd3;
endpackage

// File: rtl/pwm_edge_sync.sv
// pwm_edge_sync: synchronizes an async PWM input and flags rising/falling edges.
// Ports: i_clk, i_rst_n (async active-low), i_pwm (async input);
//        o_pwm_s synced level, o_rise/o_fall one-cycle edge flags aligned with o_pwm_s.
// Every edge appears SYNC_STAGES+1 cycles after it arrives, identically for rise and fall.
module pwm_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pwm,
  output logic o_pwm_s,
  output logic o_rise,
  output logic o_fall
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic pwm_s_q, rise_q, fall_q;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q  <= '0;
      pwm_s_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], i_pwm};
      pwm_s_q <= sync_q[SYNC_STAGES-1];
      rise_q  <= sync_q[SYNC_STAGES-1] & ~pwm_s_q;
      fall_q  <= ~sync_q[SYNC_STAGES-1] & pwm_s_q;
    end
  end
  assign o_pwm_s = pwm_s_q;
  assign o_rise  = rise_q;
  assign o_fall  = fall_q;
endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of the last of N captured PWM periods.
// Ports: i_clk, i_rst_n (async active-low), i_start (arm/restart), i_we/i_addr/i_wdata
//        register writes, i_pwm async input; o_rdata combinational register read,
//        o_busy capture running, o_done one-cycle completion pulse, o_err sticky abort flag.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int DW          = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_we,
  input  logic [1:0]    i_addr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_pwm,
  output logic [DW-1:0] o_rdata,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err
);
  localparam logic [DW-1:0] ONES = '1;
  state_e state_q;
  logic [DW-1:0] period_q, high_q, ncap_q, timeout_q, rem_q, per_cnt_q, high_cnt_q, gap_q;
  logic err_q, pwm_s, rise, unused_fall, timeout_hit;
  pwm_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_pwm  (i_pwm),
    .o_pwm_s(pwm_s),
    .o_rise (rise),
    .o_fall (unused_fall)
  );
  assign timeout_hit = (timeout_q != '0) && (gap_q == timeout_q);
  assign o_busy  = (state_q == WAIT_RISE) || (state_q == MEASURE);
  assign o_done  = state_q == DONE;
  assign o_err   = err_q;
  assign o_rdata = i_addr == ADDR_PERIOD ? period_q :
                   i_addr == ADDR_HIGH   ? high_q   :
                   i_addr == ADDR_NCAP   ? ncap_q   : timeout_q;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      period_q   <= '0;
      high_q     <= '0;
      ncap_q     <= '0;
      timeout_q  <= '0;
      rem_q      <= '0;
      per_cnt_q  <= '0;
      high_cnt_q <= '0;
      gap_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      if (i_we && i_addr == ADDR_NCAP) ncap_q <= i_wdata;
      if (i_we && i_addr == ADDR_TIMEOUT) timeout_q <= i_wdata;
      gap_q <= (i_start || rise) ? '0 : gap_q == ONES ? gap_q : gap_q + 1'b1;
      if (i_start) begin
        state_q    <= WAIT_RISE;
        rem_q      <= ncap_q == '0 ? DW'(1) : ncap_q;
        per_cnt_q  <= '0;
        high_cnt_q <= '0;
        err_q      <= 1'b0;
      end else begin
        case (state_q)
          WAIT_RISE: begin
            if (timeout_hit) begin
              err_q   <= 1'b1;
              state_q <= IDLE;
            end else if (rise) begin
              // the rise cycle itself is already high, so it counts toward HIGH
              per_cnt_q  <= '0;
              high_cnt_q <= DW'(1);
              state_q    <= MEASURE;
            end
          end
          MEASURE: begin
            if (per_cnt_q == ONES || timeout_hit) begin
              err_q   <= 1'b1;
              state_q <= IDLE;
            end else if (rise) begin
              period_q   <= per_cnt_q + 1'b1;
              high_q     <= high_cnt_q;
              rem_q      <= rem_q - 1'b1;
              per_cnt_q  <= '0;
              high_cnt_q <= DW'(1);
              if (rem_q == DW'(1)) state_q <= DONE;
            end else begin
              per_cnt_q <= per_cnt_q + 1'b1;
              if (pwm_s && high_cnt_q != ONES) high_cnt_q <= high_cnt_q + 1'b1;
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule
